// File: rtl/lane_tx_pkg.sv
// Shared constants and types for the lane transmit path.
// Used by the transmit arbiter and the byte-slot generator.
package lane_tx_pkg;

  localparam logic [7:0] IDLE_BYTE_DEF  = 8'hBC;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/lane_slot_gen.sv
// Byte-slot strobe generator: divides clk_32f by CLK_DIV.
// Shared between the transmit serializer and the receive gatherer.
module lane_slot_gen
  import lane_tx_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk_32f,
  input  logic reset,
  output logic slot
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk_32f) begin
    if (!reset)
      div_cnt <= '0;
    else if (slot)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + CW'(1);
  end

  assign slot = (div_cnt == LAST);

endmodule

// File: rtl/lane_tx_arbiter.sv
// Round-robin arbiter feeding two 32-bit sources into one
// byte lane, MSB byte first, one byte per slot.
module lane_tx_arbiter
  import lane_tx_pkg::*;
#(
  parameter int         CLK_DIV   = 8,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        grant_out,
  output logic        busy
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_t      state;
  state_t      state_nx;
  logic        slot;
  logic [1:0]  byte_idx;
  logic [23:0] sreg;
  logic        last_grant;
  logic        last_byte;
  logic        load_opp;
  logic        take;
  logic        pick;
  logic [31:0] word;

  lane_slot_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_slot (
    .clk_32f (clk_32f),
    .reset   (reset),
    .slot    (slot)
  );

  assign last_byte = (state == ST_SEND) && (byte_idx == LAST_IDX);
  assign load_opp  = slot && ((state == ST_IDLE) || last_byte);

  always_ff @(posedge clk_32f) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (slot) begin
      if (take)
        state_nx = ST_SEND;
      else if (last_byte)
        state_nx = ST_IDLE;
    end
  end

  // Tie-break flips against the previous winner only when both ask.
  always_comb begin
    take       = reset && load_opp && (req0_valid || req1_valid);
    pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = take && !pick;
    req1_ready = take && pick;
    word       = pick ? req1_data : req0_data;
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      byte_idx   <= '0;
      last_grant <= 1'b1;
      sreg       <= '0;
      data_out   <= IDLE_BYTE;
      valid_out  <= 1'b0;
      grant_out  <= 1'b0;
      busy       <= 1'b0;
    end else if (slot) begin
      if (take) begin
        sreg       <= word[23:0];
        data_out   <= word[31:24];
        valid_out  <= 1'b1;
        grant_out  <= pick;
        last_grant <= pick;
        byte_idx   <= '0;
        busy       <= 1'b1;
      end else if ((state == ST_SEND) && !last_byte) begin
        byte_idx <= byte_idx + 2'd1;
        sreg     <= {sreg[15:0], 8'h00};
        data_out <= sreg[23:16];
      end else begin
        data_out  <= IDLE_BYTE;
        valid_out <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_tx_arbiter.sv
// Bench for lane_tx_arbiter: byte-queue reference model,
// directed scenarios, randomized traffic and a CLK_DIV=2 instance.
module tb_lane_tx_arbiter;

  localparam int DIV = 8;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b0;
  logic [31:0] req0_data  = '0;
  logic        req0_valid = 1'b0;
  logic [31:0] req1_data  = '0;
  logic        req1_valid = 1'b0;
  logic        req0_ready;
  logic        req1_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        grant_out;
  logic        busy;

  logic [31:0] d2_data  = '0;
  logic        d2_valid = 1'b0;
  logic [31:0] z_data   = '0;
  logic        z_valid  = 1'b0;
  logic        u2_r0;
  logic        u2_r1;
  logic [7:0]  u2_data;
  logic        u2_valid;
  logic        u2_grant;
  logic        u2_busy;

  always #5 clk_32f = ~clk_32f;

  lane_tx_arbiter #(.CLK_DIV(DIV)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .grant_out  (grant_out),
    .busy       (busy)
  );

  lane_tx_arbiter #(.CLK_DIV(2)) u2 (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .req0_data  (d2_data),
    .req0_valid (d2_valid),
    .req0_ready (u2_r0),
    .req1_data  (z_data),
    .req1_valid (z_valid),
    .req1_ready (u2_r1),
    .data_out   (u2_data),
    .valid_out  (u2_valid),
    .grant_out  (u2_grant),
    .busy       (u2_busy)
  );

  // Reference model: edges since release plus a queue of bytes still owed.
  int         n = 0;
  logic [7:0] pend[$];
  logic       m_last  = 1'b1;
  logic [7:0] m_data  = 8'hBC;
  logic       m_valid = 1'b0;
  logic       m_grant = 1'b0;
  logic       m_busy  = 1'b0;
  logic       p_r0, p_r1, a_r0, a_r1, a2_r;
  int         checks   = 0;
  int         failures = 0;

  task automatic cycle();
    logic        slot_n;
    logic        opp;
    logic        sel;
    logic [31:0] w;
    #1;
    a_r0   = req0_ready;
    a_r1   = req1_ready;
    a2_r   = u2_r0;
    slot_n = reset && (((n + 1) % DIV) == 0);
    opp    = slot_n && (pend.size() == 0);
    sel    = (req0_valid && req1_valid) ? !m_last : req1_valid;
    p_r0   = opp && req0_valid && !sel;
    p_r1   = opp && req1_valid && sel;
    @(posedge clk_32f);
    if (!reset) begin
      n = 0;
      pend.delete();
      m_last  = 1'b1;
      m_data  = 8'hBC;
      m_valid = 1'b0;
      m_grant = 1'b0;
      m_busy  = 1'b0;
    end else begin
      n++;
      if (slot_n) begin
        if (p_r0 || p_r1) begin
          w = p_r1 ? req1_data : req0_data;
          for (int i = 3; i >= 0; i--) pend.push_back(w[8*i +: 8]);
          m_last  = p_r1;
          m_grant = p_r1;
        end
        if (pend.size() > 0) begin
          m_data  = pend.pop_front();
          m_valid = 1'b1;
          m_busy  = 1'b1;
        end else begin
          m_data  = 8'hBC;
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end
    end
    @(negedge clk_32f);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({a_r0, a_r1, data_out, valid_out, grant_out, busy} !==
        {1'b0, 1'b0, 8'hBC, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h",
               {a_r0, a_r1, data_out, valid_out, grant_out, busy},
               {1'b0, 1'b0, 8'hBC, 3'b000});
    end
    req1_valid = 1'b0;
    reset = 1'b1;
    seen  = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (a_r0 || a_r1) seen++;
      checks++;
      if ({data_out, valid_out, busy} !== {8'hBC, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL idle_line edge=%0d got=%h/%b/%b want=bc/0/0",
                 n, data_out, valid_out, busy);
      end
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL idle_ready got=%0d want=0", seen);
    end
  endtask

  task automatic test_single();
    int acc;
    int vcnt;
    apply_reset();
    req0_data  = 32'hDEADBEEF;
    req0_valid = 1'b1;
    acc  = -1;
    vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (a_r0) begin
        acc = n;
        req0_valid = 1'b0;
      end
      if (valid_out) vcnt++;
      checks++;
      if ({a_r0, a_r1, data_out, valid_out, grant_out, busy} !==
          {p_r0, p_r1, m_data, m_valid, m_grant, m_busy}) begin
        failures++;
        $display("FAIL single edge=%0d got=%h want=%h", n,
                 {a_r0, a_r1, data_out, valid_out, grant_out, busy},
                 {p_r0, p_r1, m_data, m_valid, m_grant, m_busy});
      end
    end
    checks++;
    if (acc !== 8) begin
      failures++;
      $display("FAIL single_accept_edge got=%0d want=8", acc);
    end
    checks++;
    if (vcnt !== 4 * DIV) begin
      failures++;
      $display("FAIL single_word_time got=%0d want=%0d", vcnt, 4 * DIV);
    end
  endtask

  task automatic test_alternate();
    int k;
    int gaps;
    apply_reset();
    req0_data  = 32'hA1A2A3A4;
    req1_data  = 32'hB1B2B3B4;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    k    = 0;
    gaps = 0;
    for (int c = 0; c < 300; c++) begin
      cycle();
      if (a_r0 || a_r1) begin
        checks++;
        if ({a_r0, a_r1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL alternate word=%0d got=%b want_src=%0d",
                   k, {a_r0, a_r1}, k % 2);
        end
        k++;
      end
      if (n >= 8 && !valid_out) gaps++;
      checks++;
      if ({a_r0, a_r1, data_out, valid_out, grant_out, busy} !==
          {p_r0, p_r1, m_data, m_valid, m_grant, m_busy}) begin
        failures++;
        $display("FAIL alt_stream edge=%0d got=%h want=%h", n,
                 {a_r0, a_r1, data_out, valid_out, grant_out, busy},
                 {p_r0, p_r1, m_data, m_valid, m_grant, m_busy});
      end
    end
    checks++;
    if (gaps !== 0 || k < 8) begin
      failures++;
      $display("FAIL alt_gapless got gaps=%0d words=%0d want 0/>=8",
               gaps, k);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_late_req1();
    int acc1;
    int gaps;
    apply_reset();
    req0_data  = 32'h0A0B0C0D;
    req1_data  = 32'h55667788;
    req0_valid = 1'b1;
    acc1 = -1;
    gaps = 0;
    for (int c = 0; c < 90; c++) begin
      if (n == 35) req1_valid = 1'b1;
      cycle();
      if (a_r0) req0_valid = 1'b0;
      if (a_r1) begin
        acc1 = n;
        req1_valid = 1'b0;
      end
      if (n >= 8 && n < 72 && !valid_out) gaps++;
      checks++;
      if ({a_r0, a_r1, data_out, valid_out, grant_out, busy} !==
          {p_r0, p_r1, m_data, m_valid, m_grant, m_busy}) begin
        failures++;
        $display("FAIL late_req1 edge=%0d got=%h want=%h", n,
                 {a_r0, a_r1, data_out, valid_out, grant_out, busy},
                 {p_r0, p_r1, m_data, m_valid, m_grant, m_busy});
      end
    end
    checks++;
    if (acc1 !== 40 || gaps !== 0) begin
      failures++;
      $display("FAIL late_req1_boundary got edge=%0d gaps=%0d want 40/0",
               acc1, gaps);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    logic src;
    apply_reset();
    req0_data  = 32'h11223344;
    req0_valid = 1'b1;
    while (n < 26) begin
      cycle();
      if (a_r0) req0_valid = 1'b0;
    end
    checks++;
    if ({data_out, valid_out} !== {8'h33, 1'b1}) begin
      failures++;
      $display("FAIL mid_byte2 got=%h/%b want=33/1", data_out, valid_out);
    end
    reset      = 1'b0;
    req1_data  = 32'h0BADF00D;
    req1_valid = 1'b1;
    cycle();
    checks++;
    if ({a_r0, a_r1, data_out, valid_out, grant_out, busy} !==
        {1'b0, 1'b0, 8'hBC, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset got=%h want=%h",
               {a_r0, a_r1, data_out, valid_out, grant_out, busy},
               {2'b00, 8'hBC, 3'b000});
    end
    reset      = 1'b1;
    req0_data  = 32'hCAFEF00D;
    req0_valid = 1'b1;
    acc = -1;
    src = 1'bx;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if ((a_r0 || a_r1) && acc < 0) begin
        acc = n;
        src = a_r1;
      end
      if (a_r0) req0_valid = 1'b0;
      if (a_r1) req1_valid = 1'b0;
    end
    checks++;
    if (acc !== 8 || src !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart got edge=%0d src=%b want 8/0", acc, src);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 999) != 0);
      if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1'b1;
        req0_data  = $urandom;
      end else if (req0_valid && $urandom_range(0, 49) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1'b1;
        req1_data  = $urandom;
      end else if (req1_valid && $urandom_range(0, 49) == 0) begin
        req1_valid = 1'b0;
      end
      cycle();
      if (a_r0) begin
        req0_valid = $urandom_range(0, 1) == 1;
        req0_data  = $urandom;
      end
      if (a_r1) begin
        req1_valid = $urandom_range(0, 1) == 1;
        req1_data  = $urandom;
      end
      checks++;
      if ({a_r0, a_r1, data_out, valid_out, grant_out, busy} !==
          {p_r0, p_r1, m_data, m_valid, m_grant, m_busy}) begin
        failures++;
        $display("FAIL random edge=%0d got=%h want=%h", n,
                 {a_r0, a_r1, data_out, valid_out, grant_out, busy},
                 {p_r0, p_r1, m_data, m_valid, m_grant, m_busy});
      end
    end
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_div2();
    logic [31:0] w2;
    logic [7:0]  eb;
    logic        ev;
    int          vcnt;
    w2 = 32'h01020304;
    d2_data  = w2;
    d2_valid = 1'b1;
    apply_reset();
    vcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (a2_r) d2_valid = 1'b0;
      ev = (n >= 2) && (n <= 9);
      eb = ev ? w2[8*(3 - (n - 2) / 2) +: 8] : 8'hBC;
      if (u2_valid) vcnt++;
      checks++;
      if ({a2_r, u2_data, u2_valid, u2_grant} !==
          {(n == 2), eb, ev, 1'b0}) begin
        failures++;
        $display("FAIL div2 edge=%0d got=%h want=%h", n,
                 {a2_r, u2_data, u2_valid, u2_grant},
                 {(n == 2), eb, ev, 1'b0});
      end
    end
    checks++;
    if (vcnt !== 8) begin
      failures++;
      $display("FAIL div2_word_time got=%0d want=8", vcnt);
    end
  endtask

  initial begin
    @(negedge clk_32f);
    test_reset();
    test_single();
    test_alternate();
    test_late_req1();
    test_reset_mid();
    test_random();
    test_div2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
